// File: rtl/arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } arb_owner_t;

   localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;
   localparam int unsigned STARVE_CNT_W   = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_cnt
   import arb_pkg::*;
#(
   parameter int unsigned LIM = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic sat_c
);

   logic [STARVE_CNT_W-1:0] cnt_q;
   logic [STARVE_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != STARVE_CNT_W'(LIM))) begin
         cnt_d = cnt_q + STARVE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_c = (cnt_q == STARVE_CNT_W'(LIM));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data requesters onto one single-ported memory.
// Optional ack timeout/abort is built when UNIFIED_MEM_ARBITER_TIMEOUT_EN is defined.
module unified_mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_LIM = 3
`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT    = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              if_stall,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              arb_err
);

   arb_state_t        state_q,     state_d;
   logic              mem_req_q,   mem_req_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
   logic              if_ready_q,  if_ready_d;
   logic              dm_ready_q,  dm_ready_d;
   logic              arb_err_q,   arb_err_d;

   arb_owner_t        own_c;
   logic              gnt_c;
   logic              fin_c;
   logic              abort_c;
   logic [DATA_W-1:0] fin_data_c;
   logic              starve_inc_c;
   logic              starve_clr_c;
   logic              starve_sat_c;

`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT) + 1;
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   arb_starve_cnt #(
      .LIM   (STARVE_LIM)
   ) u_starve (
      .clk   (clk),
      .reset (reset),
      .inc   (starve_inc_c),
      .clr   (starve_clr_c),
      .sat_c (starve_sat_c)
   );

   // Grant selection: data normally wins, fetch wins once data has starved it.
   always_comb begin
      own_c = OWN_IF;
      gnt_c = 1'b0;
      if (dm_req && !(if_req && starve_sat_c)) begin
         own_c = OWN_DM;
         gnt_c = 1'b1;
      end else if (if_req) begin
         own_c = OWN_IF;
         gnt_c = 1'b1;
      end
   end

   // Transfer completion: memory ack, or an abort when the wait runs out.
   always_comb begin
      fin_c      = mem_ack;
      fin_data_c = mem_rdata;
      abort_c    = 1'b0;
`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
      if (!mem_ack && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
         fin_c      = 1'b1;
         fin_data_c = DATA_W'(ARB_ABORT_DATA);
         abort_c    = 1'b1;
      end
`endif
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      dm_rdata_d   = dm_rdata_q;
      if_ready_d   = 1'b0;
      dm_ready_d   = 1'b0;
      arb_err_d    = 1'b0;
      starve_inc_c = 1'b0;
      starve_clr_c = 1'b0;
`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
      tmo_d        = tmo_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (gnt_c) begin
               mem_req_d = 1'b1;
`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
               tmo_d     = '0;
`endif
               if (own_c == OWN_DM) begin
                  state_d      = BUSY_D;
                  mem_we_d     = dm_we;
                  mem_addr_d   = dm_addr;
                  mem_wdata_d  = dm_wdata;
                  starve_inc_c = if_req;
                  starve_clr_c = !if_req;
               end else begin
                  state_d      = BUSY_I;
                  mem_we_d     = 1'b0;
                  mem_addr_d   = if_addr;
                  mem_wdata_d  = '0;
                  starve_clr_c = 1'b1;
               end
            end
         end
         BUSY_I, BUSY_D: begin
`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
            tmo_d = tmo_q + TMO_W'(1);
`endif
            if (fin_c) begin
               mem_req_d = 1'b0;
               state_d   = RESP;
               arb_err_d = abort_c;
               if (state_q == BUSY_I) begin
                  if_rdata_d = fin_data_c;
                  if_ready_d = 1'b1;
               end else begin
                  dm_rdata_d = fin_data_c;
                  dm_ready_d = 1'b1;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         dm_ready_q  <= 1'b0;
         arb_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ready_q  <= if_ready_d;
         dm_ready_q  <= dm_ready_d;
         arb_err_q   <= arb_err_d;
      end
   end

`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end

   assign arb_err = arb_err_q;
`else
   assign arb_err = 1'b0;
`endif

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_ready  = if_ready_q;
   assign dm_ready  = dm_ready_q;

   // Stalls are combinational so the hazard unit sees them in the request cycle.
   assign if_stall  = if_req & ~if_ready_q;
   assign dm_stall  = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter; the timeout case runs only
// when UNIFIED_MEM_ARBITER_TIMEOUT_EN is defined.
module tb_unified_mem_arbiter;
   import arb_pkg::*;

   typedef struct {
      logic [31:0] data;
      bit          chk_data;
      bit          err;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
   } gnt_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ready;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ready;
   logic        if_stall;
   logic        dm_stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        arb_err;

   int checks   = 0;
   int failures = 0;

   exp_t if_q[$];
   exp_t dm_q[$];
   gnt_t gnt_q[$];

   int   ack_delay = 0;
   int   ack_wait  = 0;
   logic force_ack = 1'b0;
   logic mem_req_prev = 1'b0;
   int   if_ready_cnt = 0;
   int   dm_ready_cnt = 0;

   unified_mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ready  (if_ready),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_ready  (dm_ready),
      .if_stall  (if_stall),
      .dm_stall  (dm_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .arb_err   (arb_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hE3A0_0001;
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push_if(input logic [31:0] a, input bit err);
      exp_t e;
      e.data = err ? 32'hDEADBEEF : mem_model(a);
      e.chk_data = 1'b1;
      e.err = err;
      if_q.push_back(e);
   endtask

   task automatic push_dm(input logic [31:0] a, input logic we);
      exp_t e;
      e.data = mem_model(a);
      e.chk_data = !we;
      e.err = 1'b0;
      dm_q.push_back(e);
   endtask

   task automatic push_gnt(input logic we, input logic [31:0] a);
      gnt_t g;
      g.we = we;
      g.addr = a;
      gnt_q.push_back(g);
   endtask

   // Memory model: acks after ack_delay extra cycles of mem_req.
   always @(negedge clk) begin
      if (force_ack) begin
         mem_ack <= 1'b1;
      end else if (mem_req && !mem_ack) begin
         if (ack_wait >= ack_delay) begin
            mem_ack   <= 1'b1;
            mem_rdata <= mem_model(mem_addr);
            ack_wait  <= 0;
         end else begin
            mem_ack  <= 1'b0;
            ack_wait <= ack_wait + 1;
         end
      end else begin
         mem_ack  <= 1'b0;
         ack_wait <= 0;
      end
   end

   // Scoreboard monitor: grant order/contents and ready pulses with their data.
   always @(negedge clk) begin
      if (reset) begin
         if (mem_req && !mem_req_prev) begin
            if (gnt_q.size() == 0) begin
               chk1("gnt_unexpected", 1'b1, 1'b0);
            end else begin
               gnt_t g;
               g = gnt_q.pop_front();
               chk("gnt_addr", mem_addr, g.addr);
               chk1("gnt_we", mem_we, g.we);
            end
         end
         if (if_ready) begin
            if_ready_cnt <= if_ready_cnt + 1;
            if (if_q.size() == 0) begin
               chk1("if_ready_unexpected", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = if_q.pop_front();
               chk("if_rdata", if_rdata, e.data);
               chk1("if_arb_err", arb_err, e.err);
            end
         end
         if (dm_ready) begin
            dm_ready_cnt <= dm_ready_cnt + 1;
            if (dm_q.size() == 0) begin
               chk1("dm_ready_unexpected", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = dm_q.pop_front();
               if (e.chk_data) chk("dm_rdata", dm_rdata, e.data);
               chk1("dm_arb_err", arb_err, e.err);
            end
         end
      end
      mem_req_prev <= mem_req;
   end

   initial begin
      int   n_dm;
      int   n_req;
      int   n_rdy;
      int   saved;
      bit   seen_if;
      bit   ok;
      logic stable;

      reset    = 1'b1;
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      mem_ack  = 1'b0;
      mem_rdata = '0;
      #1 reset = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk1("rst_if_ready", if_ready, 1'b0);
      chk1("rst_dm_ready", dm_ready, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);
      chk1("rst_arb_err", arb_err, 1'b0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Fetch only, minimum latency.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h100;
      push_if(32'h100, 1'b0); push_gnt(1'b0, 32'h100);
      @(negedge clk);
      chk1("f_stall_c0", if_stall, 1'b1);
      chk1("f_mem_req_c0", mem_req, 1'b0);
      @(negedge clk);
      chk1("f_mem_req_c1", mem_req, 1'b1);
      chk("f_mem_addr_c1", mem_addr, 32'h100);
      chk1("f_mem_we_c1", mem_we, 1'b0);
      chk1("f_stall_c1", if_stall, 1'b1);
      @(negedge clk);
      chk1("f_ready_c2", if_ready, 1'b1);
      chk("f_rdata_c2", if_rdata, 32'hE3A0_0001);
      chk1("f_stall_c2", if_stall, 1'b0);
      chk1("f_mem_req_c2", mem_req, 1'b0);
      if_req = 1'b0;
      @(negedge clk);
      chk1("f_ready_c3", if_ready, 1'b0);
      repeat (2) @(negedge clk);

      // Simultaneous store and fetch: data first, fetch issued from IDLE afterwards.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h200;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h55;
      push_gnt(1'b1, 32'h40); push_gnt(1'b0, 32'h200);
      push_dm(32'h40, 1'b1); push_if(32'h200, 1'b0);
      @(negedge clk);
      chk1("s_dm_stall_c0", dm_stall, 1'b1);
      chk1("s_if_stall_c0", if_stall, 1'b1);
      @(negedge clk);
      chk1("s_mem_we_c1", mem_we, 1'b1);
      chk("s_mem_addr_c1", mem_addr, 32'h40);
      chk("s_mem_wdata_c1", mem_wdata, 32'h55);
      @(negedge clk);
      chk1("s_dm_ready_c2", dm_ready, 1'b1);
      chk1("s_if_ready_c2", if_ready, 1'b0);
      chk1("s_dm_stall_c2", dm_stall, 1'b0);
      dm_req = 1'b0;
      @(negedge clk);
      chk1("s_mem_req_c3", mem_req, 1'b0);
      chk("s_state_c3", 32'(dut.state_q), 32'(IDLE));
      @(negedge clk);
      chk1("s_mem_req_c4", mem_req, 1'b1);
      chk("s_mem_addr_c4", mem_addr, 32'h200);
      chk1("s_mem_we_c4", mem_we, 1'b0);
      @(negedge clk);
      chk1("s_if_ready_c5", if_ready, 1'b1);
      if_req = 1'b0;
      repeat (2) @(negedge clk);

      // Starvation: continuous loads with a fetch waiting.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h300;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; dm_wdata = 32'h0;
      push_gnt(1'b0, 32'h80); push_gnt(1'b0, 32'h84); push_gnt(1'b0, 32'h88);
      push_gnt(1'b0, 32'h300); push_gnt(1'b0, 32'h8C);
      push_dm(32'h80, 1'b0); push_if(32'h300, 1'b0);
      n_dm = 0; seen_if = 1'b0; ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk);
         if (if_ready) begin
            chk("starve_dm_before_if", n_dm, 3);
            chk("starve_cnt_after_fetch", 32'(dut.u_starve.cnt_q), 32'h0);
            if_req = 1'b0;
            seen_if = 1'b1;
         end
         if (dm_ready) begin
            n_dm++;
            if (n_dm < 4) begin
               dm_addr = dm_addr + 32'h4;
               push_dm(dm_addr, 1'b0);
            end else begin
               dm_req = 1'b0;
            end
         end
         ok = (n_dm == 4) && seen_if;
      end
      chk1("starve_complete", ok, 1'b1);
      repeat (2) @(negedge clk);
      chk("starve_cnt_idle", 32'(dut.u_starve.cnt_q), 32'h0);

      // Slow memory: outputs held until the late ack, one ready pulse.
      ack_delay = 5;
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'hC0; dm_wdata = 32'h1234;
      push_gnt(1'b0, 32'hC0); push_dm(32'hC0, 1'b0);
      n_req = 0; n_rdy = 0; stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_req) begin
            n_req++;
            if (mem_addr !== 32'hC0 || mem_we !== 1'b0 || mem_wdata !== 32'h1234) stable = 1'b0;
         end
         if (dm_ready) begin
            n_rdy++;
            dm_req = 1'b0;
         end
      end
      chk("slow_req_cycles", n_req, 6);
      chk1("slow_stable", stable, 1'b1);
      chk("slow_ready_pulses", n_rdy, 1);
      ack_delay = 0;

      // Spurious ack while idle is ignored.
      @(posedge clk); #1;
      saved = if_ready_cnt + dm_ready_cnt;
      force_ack = 1'b1;
      repeat (2) @(negedge clk);
      force_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk1("spur_mem_req", mem_req, 1'b0);
      chk("spur_state", 32'(dut.state_q), 32'(IDLE));
      chk("spur_ready_cnt", if_ready_cnt + dm_ready_cnt, saved);

      // Reset in the middle of a data transfer.
      ack_delay = 1000;
      @(posedge clk); #1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h50; dm_wdata = 32'hA5;
      push_gnt(1'b1, 32'h50); push_dm(32'h50, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk1("rmid_mem_req_busy", mem_req, 1'b1);
      chk("rmid_state_busy", 32'(dut.state_q), 32'(BUSY_D));
      saved = dm_ready_cnt;
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk1("rmid_mem_req_async", mem_req, 1'b0);
      chk("rmid_state_async", 32'(dut.state_q), 32'(IDLE));
      dm_req = 1'b0;
      dm_q.delete();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk1("rmid_no_ready", dm_ready, 1'b0);
      end
      reset = 1'b1;
      ack_delay = 0;
      repeat (2) @(negedge clk);
      chk("rmid_ready_cnt", dm_ready_cnt, saved);
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h104;
      push_gnt(1'b0, 32'h104); push_if(32'h104, 1'b0);
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         if (if_ready) begin
            ok = 1'b1;
            chk("rmid_after_latency", c, 2);
            if_req = 1'b0;
         end
      end
      chk1("rmid_after_ready", ok, 1'b1);
      repeat (2) @(negedge clk);

`ifdef UNIFIED_MEM_ARBITER_TIMEOUT_EN
      // No ack: abort after the timeout with the marker data and an error pulse.
      ack_delay = 1000;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h108;
      push_gnt(1'b0, 32'h108); push_if(32'h108, 1'b1);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(negedge clk);
         if (if_ready) begin
            ok = 1'b1;
            chk("tmo_latency", c, 17);
            chk1("tmo_arb_err", arb_err, 1'b1);
            chk("tmo_rdata", if_rdata, 32'hDEADBEEF);
            if_req = 1'b0;
         end
      end
      chk1("tmo_ready", ok, 1'b1);
      @(negedge clk);
      chk1("tmo_err_pulse_end", arb_err, 1'b0);
      ack_delay = 0;
      repeat (2) @(negedge clk);
`endif

      chk("if_q_empty", if_q.size(), 0);
      chk("dm_q_empty", dm_q.size(), 0);
      chk("gnt_q_empty", gnt_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
